// File: rtl/spi_slave_param.sv
// Parametrised SPI slave: MOSI frames to command words, RAM read data on MISO.
// Define SPI_SLAVE_ERR_EN to enable frame_err reporting and rd_armed gating.
module spi_slave_param #(
  parameter int DATA_W     = 8,
  parameter int TX_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              SS_n,
  input  logic              MOSI,
  output logic              MISO,
  output logic [DATA_W+1:0] rx_data,
  output logic              rx_valid,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              frame_err
);

`ifdef SPI_SLAVE_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  localparam int W  = DATA_W + 2;
  localparam int CW = $clog2(W + 1);
  localparam int TW = $clog2(TX_TIMEOUT + 1);
  localparam int BW = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] LP_LAST  = CW'(W - 1);
  localparam logic [TW-1:0] LP_TLAST = TW'(TX_TIMEOUT - 1);
  localparam logic [BW-1:0] LP_BTOP  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_WAIT_TX,
    S_SEND,
    S_DONE
  } state_t;

  state_t            r_state;
  logic [W-2:0]      r_shift;
  logic [CW-1:0]     r_cnt;
  logic [TW-1:0]     r_wait;
  logic [BW-1:0]     r_bit;
  logic [DATA_W-1:0] r_tx;
  logic              r_armed;
  logic              r_miso;
  logic [W-1:0]      r_rx_data;
  logic              r_rx_valid;
  logic              r_err;

  logic [W-1:0] w_next;
  logic [1:0]   w_cmd;
  logic         w_reject;

  assign w_next   = {r_shift, MOSI};
  assign w_cmd    = w_next[W-1:W-2];
  // A read-data frame with no preceding read-address is refused
  assign w_reject = ERR_EN && (w_cmd == 2'b11) && !r_armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shift    <= '0;
      r_cnt      <= '0;
      r_wait     <= '0;
      r_bit      <= '0;
      r_tx       <= '0;
      r_armed    <= 1'b0;
      r_miso     <= 1'b0;
      r_rx_data  <= '0;
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_err      <= 1'b0;
      if (SS_n) begin
        r_state <= S_IDLE;
        r_cnt   <= '0;
        r_miso  <= 1'b0;
        // RECV always holds a partial frame (1..W-1 bits)
        if (ERR_EN && r_state == S_RECV) r_err <= 1'b1;
      end else begin
        unique case (r_state)
          S_IDLE: begin
            r_miso  <= 1'b0;
            r_shift <= {{(W-2){1'b0}}, MOSI};
            r_cnt   <= CW'(1);
            r_state <= S_RECV;
          end
          S_RECV: begin
            r_shift <= w_next[W-2:0];
            r_cnt   <= r_cnt + 1'b1;
            if (r_cnt == LP_LAST) begin
              r_wait <= '0;
              if (w_reject) begin
                r_err   <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_rx_data  <= w_next;
                r_rx_valid <= 1'b1;
                if (w_cmd == 2'b10) r_armed <= 1'b1;
                if (w_cmd == 2'b11) r_armed <= 1'b0;
                r_state <= (w_cmd == 2'b11) ? S_WAIT_TX : S_DONE;
              end
            end
          end
          S_WAIT_TX: begin
            if (tx_valid) begin
              r_tx    <= tx_data;
              r_miso  <= tx_data[DATA_W-1];
              r_bit   <= LP_BTOP;
              r_state <= S_SEND;
            end else if (r_wait == LP_TLAST) begin
              r_err   <= ERR_EN;
              r_state <= S_DONE;
            end else begin
              r_wait <= r_wait + 1'b1;
            end
          end
          S_SEND: begin
            if (r_bit == '0) begin
              r_miso  <= 1'b0;
              r_state <= S_DONE;
            end else begin
              r_miso <= r_tx[DATA_W-2];
              r_tx   <= {r_tx[DATA_W-2:0], 1'b0};
              r_bit  <= r_bit - 1'b1;
            end
          end
          S_DONE: r_miso <= 1'b0;
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign MISO      = r_miso;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_err;

endmodule

// File: tb/tb_spi_slave_param.sv
// Self-checking bench for spi_slave_param with a transaction-level model.
// Follows SPI_SLAVE_ERR_EN so the same bench covers both builds.
module tb_spi_slave_param;

  localparam int DW = 8;
  localparam int W  = DW + 2;
  localparam int TO = 16;

`ifdef SPI_SLAVE_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          SS_n;
  logic          MOSI;
  logic          MISO;
  logic [W-1:0]  rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          frame_err;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_rxv  = 0;
  int n_err  = 0;

  logic         m_armed;
  logic [W-1:0] m_rx;

  spi_slave_param #(.DATA_W(DW), .TX_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .SS_n(SS_n), .MOSI(MOSI), .MISO(MISO),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_data(tx_data),
    .tx_valid(tx_valid), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid === 1'b1) n_rxv++;
    if (frame_err === 1'b1) n_err++;
  end

  function automatic logic fwd(input logic [W-1:0] w);
    return !(ERR && w[W-1:W-2] == 2'b11 && !m_armed);
  endfunction

  task automatic model_frame(input logic [W-1:0] w);
    if (fwd(w)) begin
      m_rx = w;
      if (w[W-1:W-2] == 2'b10) m_armed = 1'b1;
      if (w[W-1:W-2] == 2'b11) m_armed = 1'b0;
    end
  endtask

  task automatic cyc(input logic ss, input logic mo,
                     input logic tv, input logic [DW-1:0] td);
    @(negedge clk);
    SS_n = ss; MOSI = mo; tx_valid = tv; tx_data = td;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input logic [W-1:0] w, input int n,
                           output int miso_hi);
    miso_hi = 0;
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, w[W-1-i], 1'b0, DW'($urandom));
      if (MISO !== 1'b0) miso_hi++;
    end
  endtask

  task automatic gap();
    cyc(1'b1, 1'b0, 1'b0, '0);
  endtask

  function automatic logic [W-1:0] rand_frame(input logic [1:0] cmd);
    return {cmd, DW'($urandom)};
  endfunction

  task automatic test_reset();
    rst = 1'b1; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = '0;
    repeat (3) @(negedge clk);
    n_cmp++; if (MISO !== 1'b0) begin n_fail++;
      $display("FAIL reset_miso got %b want 0", MISO); end
    n_cmp++; if (rx_data !== '0) begin n_fail++;
      $display("FAIL reset_rx_data got %h want 0", rx_data); end
    n_cmp++; if (rx_valid !== 1'b0) begin n_fail++;
      $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
    n_cmp++; if (frame_err !== 1'b0) begin n_fail++;
      $display("FAIL reset_frame_err got %b want 0", frame_err); end
    rst = 1'b0;
    m_armed = 1'b0;
    m_rx = '0;
    gap();
  endtask

  task automatic test_write(input logic [W-1:0] w);
    int v0, hi;
    v0 = n_rxv;
    send_bits(w, W, hi);
    model_frame(w);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== m_rx) begin n_fail++;
      $display("FAIL write_rx got v=%b d=%h want v=1 d=%h",
               rx_valid, rx_data, m_rx); end
    cyc(1'b0, 1'b1, 1'b1, 8'hFF);
    n_cmp++; if (rx_valid !== 1'b0 || MISO !== 1'b0) begin n_fail++;
      $display("FAIL write_done got v=%b miso=%b want 0 0", rx_valid, MISO); end
    gap();
    n_cmp++; if (n_rxv - v0 != 1 || hi != 0) begin n_fail++;
      $display("FAIL write_pulses got pulses=%0d miso_hi=%0d want 1 0",
               n_rxv - v0, hi); end
  endtask

  task automatic test_read(input int d, input logic [DW-1:0] data);
    logic [W-1:0]  ra, rd;
    logic [DW-1:0] got;
    int hi, bad;
    ra = rand_frame(2'b10);
    send_bits(ra, W, hi);
    model_frame(ra);
    gap();
    rd = rand_frame(2'b11);
    send_bits(rd, W, hi);
    model_frame(rd);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== m_rx) begin n_fail++;
      $display("FAIL read_rx d=%0d got v=%b d=%h want v=1 d=%h",
               d, rx_valid, rx_data, m_rx); end
    bad = 0;
    for (int k = 0; k < d; k++) begin
      cyc(1'b0, 1'b0, 1'b0, DW'($urandom));
      if (MISO !== 1'b0) bad++;
    end
    cyc(1'b0, 1'b0, 1'b1, data);
    for (int b = DW - 1; b >= 0; b--) begin
      got[b] = MISO;
      cyc(1'b0, 1'($urandom), 1'b1, ~data);
    end
    n_cmp++; if (got !== data || bad != 0) begin n_fail++;
      $display("FAIL read_miso d=%0d got %h (wait_hi=%0d) want %h",
               d, got, bad, data); end
    n_cmp++; if (MISO !== 1'b0) begin n_fail++;
      $display("FAIL read_tail d=%0d got %b want 0", d, MISO); end
    gap();
  endtask

  task automatic test_abort(input int nb);
    logic [W-1:0] w, prev;
    int v0, e0, hi;
    prev = rx_data;
    v0 = n_rxv;
    e0 = n_err;
    w = rand_frame(2'($urandom_range(0, 2)));
    send_bits(w, nb, hi);
    cyc(1'b1, w[W-1-nb], 1'b0, '0);
    gap();
    n_cmp++; if (rx_data !== prev || n_rxv != v0) begin n_fail++;
      $display("FAIL abort%0d_rx got d=%h pulses=%0d want d=%h pulses=0",
               nb, rx_data, n_rxv - v0, prev); end
    n_cmp++; if (n_err - e0 != int'(ERR)) begin n_fail++;
      $display("FAIL abort%0d_err got %0d want %0d", nb, n_err - e0, ERR); end
  endtask

  task automatic test_timeout();
    logic [W-1:0] ra, rd;
    int hi, bad, e0;
    ra = rand_frame(2'b10);
    send_bits(ra, W, hi);
    model_frame(ra);
    gap();
    e0 = n_err;
    rd = rand_frame(2'b11);
    send_bits(rd, W, hi);
    model_frame(rd);
    n_cmp++; if (rx_valid !== 1'b1 || rx_data !== m_rx) begin n_fail++;
      $display("FAIL timeout_rx got v=%b d=%h want v=1 d=%h",
               rx_valid, rx_data, m_rx); end
    bad = 0;
    for (int k = 0; k < TO; k++) begin
      cyc(1'b0, 1'b0, 1'b0, 8'hFF);
      if (MISO !== 1'b0) bad++;
    end
    for (int k = 0; k < 2; k++) begin
      cyc(1'b0, 1'b0, 1'b1, 8'hFF);
      if (MISO !== 1'b0) bad++;
    end
    gap();
    n_cmp++; if (bad != 0) begin n_fail++;
      $display("FAIL timeout_miso got %0d high cycles want 0", bad); end
    n_cmp++; if (n_err - e0 != int'(ERR)) begin n_fail++;
      $display("FAIL timeout_err got %0d want %0d", n_err - e0, ERR); end
  endtask

  task automatic test_unarmed();
    logic [W-1:0] rd, prev;
    logic exp_v;
    int hi, e0, v0;
    e0 = n_err;
    v0 = n_rxv;
    rd = rand_frame(2'b11);
    exp_v = fwd(rd);
    prev = m_rx;
    send_bits(rd, W, hi);
    model_frame(rd);
    n_cmp++; if (rx_valid !== exp_v || rx_data !== m_rx) begin n_fail++;
      $display("FAIL unarmed_rx got v=%b d=%h want v=%b d=%h (prev %h)",
               rx_valid, rx_data, exp_v, m_rx, prev); end
    gap();
    gap();
    n_cmp++; if (n_err - e0 != int'(!exp_v) || n_rxv - v0 != int'(exp_v))
    begin n_fail++;
      $display("FAIL unarmed_cnt got err=%0d rxv=%0d want err=%0d rxv=%0d",
               n_err - e0, n_rxv - v0, !exp_v, exp_v); end
  endtask

  task automatic test_rst_midsend();
    logic [W-1:0]  ra, rd;
    logic [DW-1:0] data;
    int hi;
    ra = rand_frame(2'b10);
    send_bits(ra, W, hi);
    model_frame(ra);
    gap();
    rd = rand_frame(2'b11);
    send_bits(rd, W, hi);
    model_frame(rd);
    data = DW'($urandom) | 8'h10;
    cyc(1'b0, 1'b0, 1'b1, data);
    repeat (3) cyc(1'b0, 1'b0, 1'b0, '0);
    n_cmp++; if (MISO !== data[4]) begin n_fail++;
      $display("FAIL rst_pre_miso got %b want %b", MISO, data[4]); end
    #1 rst = 1'b1; SS_n = 1'b1;
    #1;
    n_cmp++; if (MISO !== 1'b0 || rx_valid !== 1'b0 || rx_data !== '0 ||
                 frame_err !== 1'b0) begin n_fail++;
      $display("FAIL rst_async got miso=%b v=%b d=%h e=%b want 0 0 0 0",
               MISO, rx_valid, rx_data, frame_err); end
    rst = 1'b0;
    m_armed = 1'b0;
    m_rx = '0;
    gap();
    test_unarmed();
  endtask

  initial begin
    test_reset();
    test_unarmed();
    test_write(10'h0A5);
    for (int i = 0; i < 6; i++)
      test_write(rand_frame(2'($urandom_range(0, 2))));
    test_read(2, 8'hC3);
    test_read(0, DW'($urandom));
    test_read(TO - 1, DW'($urandom));
    test_read(int'($urandom_range(1, 5)), DW'($urandom));
    test_abort(5);
    test_write(rand_frame(2'b01));
    test_abort(W - 1);
    test_abort(1);
    test_write(rand_frame(2'b00));
    test_timeout();
    test_rst_midsend();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_slave_param.md
# spi_slave_param

Parametrised SPI slave front end that turns MOSI frames into parallel command words and returns memory read data on MISO. It sits between the external SPI master and the single-port RAM wrapper, and replaces the fixed 10-bit slave. It generalises the data width, bounds the wait for RAM read data with a timeout, makes frame abort explicit, and adds optional protocol-error reporting.

## Interface
- DATA_W, 8: RAM data/address payload width; frame width W = DATA_W + 2.
- TX_TIMEOUT, 16: maximum cycles spent in WAIT_TX waiting for tx_valid; must be ≥1.
- clk  in  1  SPI clock; all sampling and driving occurs on the rising edge.
- rst  in  1  reset; asynchronous and active-high, clears all state immediately.
- SS_n  in  1  slave select, active low; frames a transaction.
- MOSI  in  1  serial input, MSB first.
- MISO  out  1  serial output, MSB first; reset value 0.
- rx_data  out  W  received frame {cmd[1:0], payload[DATA_W-1:0]}; reset value 0.
- rx_valid  out  1  one-cycle pulse, rx_data valid; reset value 0.
- tx_data  in  DATA_W  RAM read data.
- tx_valid  in  1  tx_data valid; sampled only in WAIT_TX.
- frame_err  out  1  one-cycle error pulse; reset value 0; tied 0 unless the macro is defined.

## Operation
- cmd encoding: 00 write address, 01 write data, 10 read address, 11 read data.
- States: IDLE, RECV, WAIT_TX, SEND, DONE. Reset state is IDLE. On reset, bit counter = 0, rd_armed = 0, and the shift register = 0.
- IDLE: MISO = 0. If SS_n = 0 on an edge, MOSI is shifted in as bit 1, the counter is set to 1, and the next state is RECV.
- RECV: each edge with SS_n = 0 shifts MOSI in and increments the counter. On the edge that samples bit W:
  - rx_data <= the full shift word.
  - rx_valid <= 1 for that one cycle.
  - If cmd = 11, the next state is WAIT_TX; otherwise it is DONE.
- rd_armed is set by a forwarded cmd 10 frame and cleared by a forwarded cmd 11 frame.
- WAIT_TX:
  - When tx_valid = 1, tx_data is loaded into the output shifter, MISO <= tx_data[DATA_W-1], and the next state is SEND.
  - An internal wait counter counts cycles. After TX_TIMEOUT cycles with no tx_valid, the next state is DONE and MISO stays 0.
- SEND: each edge drives the next lower bit on MISO. After bit 0 has been driven for one cycle, the next state is DONE.
- DONE: MISO = 0. The block ignores MOSI until SS_n is high.
- SS_n = 1 at any edge, in any state, forces the next state to IDLE. A partial frame is discarded, rx_data holds its previous value, and no rx_valid is issued.
- Simultaneous cases:
  - SS_n rising on the same edge as bit W: the frame is not completed.
  - tx_valid on the last timeout cycle: the data is accepted.

## Timing
- Receive latency: rx_valid is high during the cycle immediately after the W-th sampling edge.
- Read turnaround: the first MISO bit appears the cycle after the edge that samples tx_valid = 1. The RAM may assert tx_valid as early as the cycle rx_valid is high.
- Back-to-back frames need SS_n high for at least one edge between them.
- rst asserted mid-frame: all outputs drop to their reset values without waiting for a clock edge. The state returns to IDLE and rd_armed is cleared.

## Configuration
- SPI_SLAVE_ERR_EN defined: frame_err pulses for one cycle in each of these cases:
  - SS_n rises in RECV with 1 ≤ counter ≤ W-1.
  - WAIT_TX times out.
  - A cmd 11 frame completes while rd_armed = 0. That frame is rejected: no rx_valid, rx_data unchanged, next state DONE.
- SPI_SLAVE_ERR_EN undefined: frame_err is constant 0. cmd 11 is forwarded regardless of rd_armed. Timeout and abort behaviour are unchanged.

## Test plan
- DATA_W=8 write-address frame: shift 00_1010_0101 -> rx_data = 10'h0A5, rx_valid high for exactly one cycle after edge 10, MISO stays 0.
- Read-address 10_0000_0011, SS_n high, then read-data 11_xxxxxxxx with tx_valid = 1 and tx_data = 8'hC3 two cycles after rx_valid -> MISO sequence 1,1,0,0,0,0,1,1, then 0.
- SS_n raised after 5 bits -> no rx_valid, rx_data unchanged, state IDLE. frame_err pulses once with the macro and stays 0 without it.
- Read-data frame with tx_valid never asserted, TX_TIMEOUT = 16 -> DONE after 16 cycles, MISO = 0 throughout, frame_err pulse with the macro.
- With the macro, a read-data frame after reset with no prior read-address -> no rx_valid, one frame_err pulse. Without the macro -> rx_valid pulses normally.
- rst pulsed between clock edges in SEND after 3 bits -> MISO = 0 and rx_valid = 0 immediately. A subsequent read-data frame is rejected (with the macro), showing rd_armed was cleared.
